// File: rtl/preamble_ctrl_pkg.sv
// preamble_ctrl_pkg
//   Shared types and constants for the preamble sync controller.
//   - state_t        : controller states; the encoding is visible on state_o
//   - CLR_CYCLES_DEFAULT : default length of the detector clear pulse
//   - DET_CNT_WIDTH  : width of the saturating detection counter
//   - sat_inc()      : increment that sticks at all-ones
package preamble_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_SEARCH  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

  localparam int CLR_CYCLES_DEFAULT = 4;
  localparam int DET_CNT_WIDTH      = 16;

  function automatic logic [DET_CNT_WIDTH-1:0] sat_inc(input logic [DET_CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + DET_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/preamble_sync_ctrl.sv
// preamble_sync_ctrl
//   Sequencer for the preamble_detect datapath: arms/clears the detector,
//   qualifies peaks against a power-relative threshold, opens a capture
//   window of capture_len accepted beats, then holds off and re-arms (or
//   stops in one-shot mode). Reports search timeouts and a detection count.
//
//   The peak qualification compare is done inline (combinational), so a
//   qualified peak in cycle N opens the capture window in cycle N+1.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   enable, oneshot         run control (level) and one-frame mode
//   thr_shift               peak qualifies when acorr_mag > (pow_mag >> thr_shift)
//   capture_len             beats per frame (0 behaves as 1)
//   holdoff_len             dec_stb pulses to wait after a frame (0 = none)
//   timeout_len             dec_stb pulses allowed in SEARCH (0 = no timeout)
//   peak_stb, dec_stb       detector strobes
//   acorr_mag, pow_mag      detector magnitudes
//   in_tvalid, in_tready    sample stream handshake (beat = valid & ready)
//   det_clear               detector clear, high while arming
//   capture_en              frame window open
//   frame_sof, frame_eof    first / last accepted beat of a frame
//   timeout_stb             SEARCH timed out
//   detect_cnt              saturating count of qualified peaks
//   state_o, busy           current state, state != IDLE
//
// CLR_CYCLES must be at least 1.
module preamble_sync_ctrl
  import preamble_ctrl_pkg::*;
#(
  parameter int PMAG_WIDTH = 28,
  parameter int CLR_CYCLES = CLR_CYCLES_DEFAULT,
  parameter int LEN_WIDTH  = 16,
  parameter int TO_WIDTH   = 24
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     oneshot,
  input  logic [4:0]               thr_shift,
  input  logic [LEN_WIDTH-1:0]     capture_len,
  input  logic [LEN_WIDTH-1:0]     holdoff_len,
  input  logic [TO_WIDTH-1:0]      timeout_len,
  input  logic                     peak_stb,
  input  logic                     dec_stb,
  input  logic [PMAG_WIDTH-1:0]    acorr_mag,
  input  logic [PMAG_WIDTH-1:0]    pow_mag,
  input  logic                     in_tvalid,
  input  logic                     in_tready,
  output logic                     det_clear,
  output logic                     capture_en,
  output logic                     frame_sof,
  output logic                     frame_eof,
  output logic                     timeout_stb,
  output logic [DET_CNT_WIDTH-1:0] detect_cnt,
  output logic [2:0]               state_o,
  output logic                     busy
);

  localparam int CLR_CW = $clog2(CLR_CYCLES + 1);

  state_t state_reg, state_next;

  // Shadow copies of the run configuration, captured on leaving IDLE.
  logic [4:0]           thr_sh_reg;
  logic [LEN_WIDTH-1:0] cap_len_reg;
  logic [LEN_WIDTH-1:0] hold_len_reg;
  logic [TO_WIDTH-1:0]  to_len_reg;
  logic                 oneshot_reg;

  logic [CLR_CW-1:0]        clr_cnt_reg;
  logic [TO_WIDTH-1:0]      timer_reg;
  logic [LEN_WIDTH-1:0]     beat_cnt_reg;
  logic [LEN_WIDTH-1:0]     hold_cnt_reg;
  logic                     abort_reg;
  logic [DET_CNT_WIDTH-1:0] det_cnt_reg;

  logic beat;
  logic qual_peak;
  logic last_beat;
  logic timer_hit;
  logic hold_done;
  logic clr_done;
  logic latch_cfg;
  logic count_det;

  assign beat      = in_tvalid & in_tready;
  assign qual_peak = peak_stb && (acorr_mag > (pow_mag >> thr_sh_reg));
  // cap_len_reg is never 0 (0 is stored as 1), so the subtraction cannot wrap.
  assign last_beat = (beat_cnt_reg == cap_len_reg - LEN_WIDTH'(1));
  assign timer_hit = dec_stb && (to_len_reg != '0) &&
                     (timer_reg + TO_WIDTH'(1) == to_len_reg);
  assign hold_done = (hold_len_reg == '0) ||
                     (dec_stb && (hold_cnt_reg + LEN_WIDTH'(1) == hold_len_reg));
  assign clr_done  = (clr_cnt_reg == CLR_CW'(CLR_CYCLES - 1));

  always_comb begin
    state_next  = state_reg;
    det_clear   = 1'b0;
    capture_en  = 1'b0;
    frame_sof   = 1'b0;
    frame_eof   = 1'b0;
    timeout_stb = 1'b0;
    latch_cfg   = 1'b0;
    count_det   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (enable) begin
          latch_cfg  = 1'b1;
          state_next = ST_ARM;
        end
      end
      ST_ARM: begin
        det_clear = 1'b1;
        if (!enable)       state_next = ST_IDLE;
        else if (clr_done) state_next = ST_SEARCH;
      end
      ST_SEARCH: begin
        // A qualified peak takes priority over a coincident timeout.
        if (!enable) begin
          state_next = ST_IDLE;
        end else if (qual_peak) begin
          count_det  = 1'b1;
          state_next = ST_CAPTURE;
        end else if (timer_hit) begin
          timeout_stb = 1'b1;
          state_next  = ST_ARM;
        end
      end
      ST_CAPTURE: begin
        capture_en = 1'b1;
        if (beat) begin
          frame_sof = (beat_cnt_reg == '0);
          if (last_beat) begin
            frame_eof = 1'b1;
            // A frame in flight always completes; a drop of enable at any
            // point during it sends us to IDLE instead of HOLDOFF.
            state_next = (abort_reg || !enable) ? ST_IDLE : ST_HOLDOFF;
          end
        end
      end
      ST_HOLDOFF: begin
        if (!enable)        state_next = ST_IDLE;
        else if (hold_done) state_next = oneshot_reg ? ST_IDLE : ST_ARM;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      thr_sh_reg   <= '0;
      cap_len_reg  <= '0;
      hold_len_reg <= '0;
      to_len_reg   <= '0;
      oneshot_reg  <= 1'b0;
      clr_cnt_reg  <= '0;
      timer_reg    <= '0;
      beat_cnt_reg <= '0;
      hold_cnt_reg <= '0;
      abort_reg    <= 1'b0;
      det_cnt_reg  <= '0;
    end else begin
      state_reg <= state_next;

      if (latch_cfg) begin
        thr_sh_reg   <= thr_shift;
        cap_len_reg  <= (capture_len == '0) ? LEN_WIDTH'(1) : capture_len;
        hold_len_reg <= holdoff_len;
        to_len_reg   <= timeout_len;
        oneshot_reg  <= oneshot;
      end

      // Restarts from zero on every entry to ARM.
      if (state_reg == ST_ARM && state_next == ST_ARM) clr_cnt_reg <= clr_cnt_reg + CLR_CW'(1);
      else                                             clr_cnt_reg <= '0;

      // Held at zero outside SEARCH, so it is clear on entry.
      if (state_reg != ST_SEARCH) timer_reg <= '0;
      else if (dec_stb)           timer_reg <= timer_reg + TO_WIDTH'(1);

      if (state_reg != ST_CAPTURE) beat_cnt_reg <= '0;
      else if (beat)               beat_cnt_reg <= beat_cnt_reg + LEN_WIDTH'(1);

      if (state_reg != ST_CAPTURE) abort_reg <= 1'b0;
      else if (!enable)            abort_reg <= 1'b1;

      if (state_reg != ST_HOLDOFF) hold_cnt_reg <= '0;
      else if (dec_stb)            hold_cnt_reg <= hold_cnt_reg + LEN_WIDTH'(1);

      if (count_det) det_cnt_reg <= sat_inc(det_cnt_reg);
    end
  end

  assign detect_cnt = det_cnt_reg;
  assign state_o    = state_reg;
  assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_preamble_sync_ctrl.sv
// Testbench for preamble_sync_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the controller.
module tb_preamble_sync_ctrl;

  localparam int CLR = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable, oneshot;
  logic [4:0]  thr_shift;
  logic [15:0] capture_len, holdoff_len;
  logic [23:0] timeout_len;
  logic        peak_stb, dec_stb;
  logic [27:0] acorr_mag, pow_mag;
  logic        in_tvalid, in_tready;
  logic        det_clear, capture_en, frame_sof, frame_eof, timeout_stb, busy;
  logic [15:0] detect_cnt;
  logic [2:0]  state_o;

  preamble_sync_ctrl dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .oneshot(oneshot),
    .thr_shift(thr_shift), .capture_len(capture_len), .holdoff_len(holdoff_len),
    .timeout_len(timeout_len), .peak_stb(peak_stb), .dec_stb(dec_stb),
    .acorr_mag(acorr_mag), .pow_mag(pow_mag), .in_tvalid(in_tvalid),
    .in_tready(in_tready), .det_clear(det_clear), .capture_en(capture_en),
    .frame_sof(frame_sof), .frame_eof(frame_eof), .timeout_stb(timeout_stb),
    .detect_cnt(detect_cnt), .state_o(state_o), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (checked every negedge) ----------------
  // mode: 0 idle, 1 arm, 2 search, 3 capture, 4 holdoff
  int     m_mode, m_det, m_arm_left, m_tcnt, m_beats, m_hseen, m_thr;
  longint m_cap, m_hold, m_to;
  bit     m_one, m_abort;

  always @(negedge clk) begin : model
    bit     beat, e_qual, e_sof, e_eof, e_tmo;
    longint e_cap;
    if (!reset_n) begin
      m_mode = 0; m_det = 0; m_arm_left = 0; m_tcnt = 0; m_beats = 0;
      m_hseen = 0; m_thr = 0; m_cap = 0; m_hold = 0; m_to = 0;
      m_one = 0; m_abort = 0;
    end
    beat   = in_tvalid && in_tready;
    e_cap  = (m_cap == 0) ? 1 : m_cap;
    e_qual = (m_mode == 2) && enable && peak_stb &&
             (longint'(acorr_mag) > longint'(pow_mag) / (longint'(1) << m_thr));
    e_sof  = (m_mode == 3) && beat && (m_beats == 0);
    e_eof  = (m_mode == 3) && beat && (m_beats + 1 == e_cap);
    e_tmo  = (m_mode == 2) && enable && !e_qual && dec_stb && (m_to != 0) &&
             (m_tcnt + 1 == m_to);

    chk("det_clear",   det_clear,   m_mode == 1);
    chk("capture_en",  capture_en,  m_mode == 3);
    chk("frame_sof",   frame_sof,   e_sof);
    chk("frame_eof",   frame_eof,   e_eof);
    chk("timeout_stb", timeout_stb, e_tmo);
    chk("detect_cnt",  detect_cnt,  m_det);
    chk("state_o",     state_o,     m_mode);
    chk("busy",        busy,        m_mode != 0);

    if (e_eof) $display("frame eof t=%0t len=%0d detect_cnt=%0d", $time, e_cap, m_det);
    if (e_tmo) $display("search timeout t=%0t after %0d dec_stb", $time, m_to);

    if (reset_n) begin
      case (m_mode)
        0: if (enable) begin
             m_thr = thr_shift; m_cap = capture_len; m_hold = holdoff_len;
             m_to = timeout_len; m_one = oneshot;
             m_mode = 1; m_arm_left = CLR;
           end
        1: if (!enable) m_mode = 0;
           else begin
             m_arm_left--;
             if (m_arm_left == 0) begin m_mode = 2; m_tcnt = 0; end
           end
        2: if (!enable) m_mode = 0;
           else if (e_qual) begin
             if (m_det < 65535) m_det++;
             m_mode = 3; m_beats = 0; m_abort = 0;
           end else if (e_tmo) begin
             m_mode = 1; m_arm_left = CLR;
           end else if (dec_stb) m_tcnt++;
        3: begin
             if (!enable) m_abort = 1;
             if (beat) begin
               if (e_eof) begin m_mode = m_abort ? 0 : 4; m_hseen = 0; end
               else m_beats++;
             end
           end
        default: if (!enable) m_mode = 0;
           else if (m_hold == 0 || (dec_stb && m_hseen + 1 == m_hold)) begin
             m_mode = m_one ? 0 : 1; m_arm_left = CLR;
           end else if (dec_stb) m_hseen++;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  logic       s_clr, s_cap, s_sof, s_eof, s_tmo, s_beat;
  logic [2:0] s_state;
  logic [15:0] s_det;

  // Holds the current inputs for one cycle; snapshot is that cycle's outputs.
  task automatic cyc();
    @(negedge clk);
    s_clr = det_clear; s_cap = capture_en; s_sof = frame_sof; s_eof = frame_eof;
    s_tmo = timeout_stb; s_state = state_o; s_det = detect_cnt;
    s_beat = in_tvalid && in_tready;
    @(posedge clk); #1;
  endtask

  task automatic wait_search(input string nm);
    int k;
    for (k = 0; k < 40; k++) begin
      cyc();
      if (s_state == 3'd2) break;
    end
    chk(nm, s_state, 2);
  endtask

  initial begin
    int n, nb, sof_at, eof_at, k;
    bit eof_seen, saw_hold;
    reset_n = 1'b1; enable = 0; oneshot = 0; thr_shift = 0; capture_len = 0;
    holdoff_len = 0; timeout_len = 0; peak_stb = 0; dec_stb = 0;
    acorr_mag = 0; pow_mag = 0; in_tvalid = 0; in_tready = 0;
    #2 reset_n = 1'b0;
    #1;
    chk("reset_state", state_o, 0);
    chk("reset_busy", busy, 0);
    chk("reset_detect_cnt", detect_cnt, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Arm: det_clear for exactly CLR cycles, then SEARCH.
    thr_shift = 2; capture_len = 8; holdoff_len = 0; timeout_len = 0; oneshot = 1;
    in_tvalid = 1; in_tready = 1; pow_mag = 400; enable = 1;
    n = 0;
    for (k = 0; k < 20; k++) begin
      cyc();
      if (s_clr) n++;
      if (s_state == 3'd2) break;
    end
    chk("arm_clr_cycles", n, 4);
    chk("arm_to_search", s_state, 2);

    // Unqualified peak: 100 is not > 400>>2.
    peak_stb = 1; acorr_mag = 100; cyc(); peak_stb = 0; cyc();
    chk("unqual_state", s_state, 2);
    chk("unqual_count", s_det, 0);

    // Qualified peak: 101 > 100, 8-beat frame with tready high.
    peak_stb = 1; acorr_mag = 101; cyc(); peak_stb = 0;
    cyc();
    chk("peak_latency_cap", s_cap, 1);
    chk("qual_count", s_det, 1);
    n = 1; sof_at = s_sof ? 1 : 0; eof_at = s_eof ? 1 : 0;
    for (k = 0; k < 20; k++) begin
      cyc();
      if (!s_cap) break;
      n++;
      if (s_sof) sof_at = n;
      if (s_eof) eof_at = n;
    end
    chk("frame_cap_cycles", n, 8);
    chk("frame_sof_beat", sof_at, 1);
    chk("frame_eof_beat", eof_at, 8);
    chk("frame_then_holdoff", s_state, 4);
    cyc();
    chk("oneshot_idle", s_state, 0);
    enable = 0; cyc();

    // Backpressure: tready alternates starting high on the first CAPTURE cycle.
    capture_len = 4; enable = 1;
    wait_search("bp_search");
    peak_stb = 1; cyc(); peak_stb = 0; in_tready = 1;
    n = 0; nb = 0; eof_at = 0;
    for (k = 0; k < 20; k++) begin
      cyc();
      in_tready = !in_tready;
      if (!s_cap) break;
      n++;
      if (s_beat) nb++;
      if (s_eof) eof_at = n;
    end
    chk("bp_cap_cycles", n, 7);
    chk("bp_beats", nb, 4);
    chk("bp_eof_cycle", eof_at, 7);
    in_tready = 1; enable = 0; cyc(); cyc();

    // Timeout after 5 dec_stb in SEARCH, then re-arm.
    timeout_len = 5; dec_stb = 1; oneshot = 0; enable = 1;
    n = 0;
    for (k = 0; k < 40; k++) begin
      cyc();
      if (s_state == 3'd2) n++;
      if (s_tmo) break;
    end
    chk("timeout_dec_count", n, 5);
    cyc();
    chk("timeout_rearm_state", s_state, 1);
    chk("timeout_rearm_clear", s_clr, 1);

    // Qualified peak coincident with the 5th dec_stb wins.
    n = 0;
    for (k = 0; k < 40; k++) begin
      cyc();
      if (s_state == 3'd2) n++;
      if (n == 4) break;
    end
    peak_stb = 1; acorr_mag = 101; cyc(); peak_stb = 0;
    chk("coinc_no_timeout", s_tmo, 0);
    cyc();
    chk("coinc_capture", s_state, 3);

    // enable dropped mid-frame: frame completes, then IDLE without HOLDOFF.
    enable = 0; eof_seen = 0; saw_hold = 0;
    for (k = 0; k < 20; k++) begin
      cyc();
      if (s_eof) eof_seen = 1;
      if (s_state == 3'd4) saw_hold = 1;
      if (s_state == 3'd0) break;
    end
    chk("abort_eof_seen", eof_seen, 1);
    chk("abort_no_holdoff", saw_hold, 0);
    chk("abort_idle", s_state, 0);
    dec_stb = 0; timeout_len = 0; capture_len = 8;

    // Reset mid-frame: everything drops at once.
    enable = 1;
    wait_search("rst_search");
    peak_stb = 1; cyc(); peak_stb = 0;
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_capture_en", capture_en, 0);
    chk("midrst_eof", frame_eof, 0);
    chk("midrst_state", state_o, 0);
    chk("midrst_detect_cnt", detect_cnt, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0) enable = !enable;
      oneshot     = ($urandom_range(0, 3) == 0);
      thr_shift   = 5'($urandom_range(0, 4));
      capture_len = 16'($urandom_range(0, 6));
      holdoff_len = 16'($urandom_range(0, 4));
      timeout_len = 24'($urandom_range(0, 12));
      peak_stb    = ($urandom_range(0, 7) == 0);
      dec_stb     = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) begin
        pow_mag   = 28'($urandom);
        acorr_mag = 28'($urandom);
      end else begin
        pow_mag   = 28'($urandom_range(0, 1023));
        acorr_mag = 28'($urandom_range(0, 300));
      end
      in_tvalid = ($urandom_range(0, 3) != 0);
      in_tready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
